// File: rtl/dmshr_arb.sv
// MSHR-to-memory refill arbiter: one outstanding request slot, per-entry issued tracking, response routing.
// Define DMSHR_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module dmshr_arb #(
  parameter int N_MSHR  = 4,
  parameter int PADDR_W = 64,
  parameter int ID_W    = $clog2(N_MSHR)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_MSHR-1:0]           dmshr2arb_valid,
  input  logic [N_MSHR*PADDR_W-1:0]   dmshr2arb_paddr,
  output logic [N_MSHR-1:0]           arb2dmshr_grant,
  output logic [N_MSHR-1:0]           arb2dmshr_resp_valid,
  output logic                        arb2mem_req_valid,
  output logic [PADDR_W-1:0]          arb2mem_req_paddr,
  output logic [ID_W-1:0]             arb2mem_req_id,
  input  logic                        mem2arb_req_ready,
  input  logic                        mem2arb_resp_valid,
  input  logic [ID_W-1:0]             mem2arb_resp_id
);
  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              r_state;
  logic [N_MSHR-1:0]   r_issued, w_issued_nxt, w_elig, w_grant, w_resp;
  logic [PADDR_W-1:0]  r_paddr, w_win_paddr;
  logic [ID_W-1:0]     r_id, w_id_nxt, w_win;
  logic                w_any, w_hs, w_resp_ok;

  assign w_hs      = (r_state == S_REQ) & mem2arb_req_ready;
  assign w_resp_ok = mem2arb_resp_valid & r_issued[mem2arb_resp_id];
  assign w_id_nxt  = (r_id == ID_W'(N_MSHR-1)) ? '0 : r_id + 1'b1;

  // The pending request is not yet marked issued, so exclude it explicitly.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_MSHR; i++)
      w_elig[i] = dmshr2arb_valid[i] & ~r_issued[i] & ~((r_state == S_REQ) && (r_id == ID_W'(i)));
  end

`ifdef DMSHR_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N_MSHR-1; k >= 0; k--)
      if (w_elig[k]) begin
        w_any = 1'b1;
        w_win = ID_W'(k);
      end
  end
`else
  logic [ID_W-1:0] r_rr_ptr, w_base, w_idx;

  // On a handshake, scan from the slot after the one just accepted.
  assign w_base = w_hs ? w_id_nxt : r_rr_ptr;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < N_MSHR; k++) begin
      w_idx = ID_W'((int'(w_base) + k) % N_MSHR);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  r_rr_ptr <= '0;
    else if (w_hs) r_rr_ptr <= w_id_nxt;
  end
`endif

  always_comb begin
    w_win_paddr = '0;
    for (int i = 0; i < N_MSHR; i++)
      if (w_win == ID_W'(i)) w_win_paddr = dmshr2arb_paddr[i*PADDR_W +: PADDR_W];
  end

  always_comb begin
    w_grant = '0;
    w_resp  = '0;
    w_issued_nxt = r_issued;
    if (w_hs) begin
      w_grant[r_id]      = 1'b1;
      w_issued_nxt[r_id] = 1'b1;
    end
    if (w_resp_ok) begin
      w_resp[mem2arb_resp_id]       = 1'b1;
      w_issued_nxt[mem2arb_resp_id] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_paddr  <= '0;
      r_id     <= '0;
      r_issued <= '0;
    end else begin
      r_issued <= w_issued_nxt;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_state <= S_REQ;
          r_paddr <= w_win_paddr;
          r_id    <= w_win;
        end
        S_REQ: if (w_hs) begin
          if (w_any) begin
            r_paddr <= w_win_paddr;
            r_id    <= w_win;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arb2mem_req_valid    = (r_state == S_REQ);
  assign arb2mem_req_paddr    = r_paddr;
  assign arb2mem_req_id       = r_id;
  assign arb2dmshr_grant      = w_grant;
  assign arb2dmshr_resp_valid = w_resp;

  a_resp_issued: assert property (@(posedge clock) disable iff (!reset_n)
    mem2arb_resp_valid |-> r_issued[mem2arb_resp_id]);
endmodule

// File: tb/tb_dmshr_arb.sv
// Directed bench for dmshr_arb: inputs driven 1ns after rising edge, outputs checked on the falling edge.
module tb_dmshr_arb;
  localparam int N = 4;
  localparam int PW = 64;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      valid = '0;
  logic [N*PW-1:0]   pbus = '0;
  logic [N-1:0]      grant, resp;
  logic              req_valid;
  logic [PW-1:0]     req_paddr;
  logic [IW-1:0]     req_id;
  logic              ready = 1'b0;
  logic              rsp_v = 1'b0;
  logic [IW-1:0]     rsp_id = '0;

  int errs = 0;
  int checks = 0;

  dmshr_arb #(.N_MSHR(N), .PADDR_W(PW), .ID_W(IW)) dut (
    .clock(clock), .reset_n(reset_n),
    .dmshr2arb_valid(valid), .dmshr2arb_paddr(pbus),
    .arb2dmshr_grant(grant), .arb2dmshr_resp_valid(resp),
    .arb2mem_req_valid(req_valid), .arb2mem_req_paddr(req_paddr), .arb2mem_req_id(req_id),
    .mem2arb_req_ready(ready), .mem2arb_resp_valid(rsp_v), .mem2arb_resp_id(rsp_id)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic set_pa(input int i, input logic [PW-1:0] a);
    pbus[i*PW +: PW] = a;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", req_valid); end
    checks++; if (req_paddr !== '0) begin errs++; $display("FAIL rst_paddr got=%h exp=0", req_paddr); end
    checks++; if (req_id !== '0) begin errs++; $display("FAIL rst_id got=%0d exp=0", req_id); end
    checks++; if (grant !== '0 || resp !== '0) begin errs++; $display("FAIL rst_pulses grant=%b resp=%b exp=0", grant, resp); end
    cyc(); reset_n = 1'b1;
  endtask

  task automatic test_single();
    cyc(); valid = 4'b0100; set_pa(2, 64'h8000_0040); ready = 1'b1;
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL single_lat got=%b exp=0", req_valid); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== 2'd2 || req_paddr !== 64'h8000_0040)
      begin errs++; $display("FAIL single_req v=%b id=%0d pa=%h exp 1/2/80000040", req_valid, req_id, req_paddr); end
    checks++; if (grant !== 4'b0100) begin errs++; $display("FAIL single_grant got=%b exp=0100", grant); end
    repeat (2) begin
      cyc(); @(negedge clock);
      checks++; if (req_valid !== 1'b0 || grant !== '0) begin errs++; $display("FAIL single_noreissue v=%b g=%b exp 0/0000", req_valid, grant); end
    end
    cyc(); valid = '0; rsp_v = 1'b1; rsp_id = 2'd2; @(negedge clock);
    checks++; if (resp !== 4'b0100) begin errs++; $display("FAIL single_resp got=%b exp=0100", resp); end
    cyc(); rsp_v = 1'b0;
  endtask

  task automatic test_rr_wrap();
    logic [IW-1:0] first, second;
`ifdef DMSHR_ARB_FIXED_PRIO_EN
    first = 2'd0; second = 2'd3;
`else
    first = 2'd3; second = 2'd0;
`endif
    valid = 4'b1001; set_pa(0, 64'h1000); set_pa(3, 64'h3000);
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL rr_idle got=%b exp=0", req_valid); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== first) begin errs++; $display("FAIL rr_first v=%b id=%0d exp 1/%0d", req_valid, req_id, first); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== second) begin errs++; $display("FAIL rr_second v=%b id=%0d exp 1/%0d", req_valid, req_id, second); end
    cyc(); valid = '0; rsp_v = 1'b1; rsp_id = 2'd3; @(negedge clock);
    checks++; if (req_valid !== 1'b0 || resp !== 4'b1000) begin errs++; $display("FAIL rr_resp3 v=%b resp=%b exp 0/1000", req_valid, resp); end
    cyc(); rsp_id = 2'd0; @(negedge clock);
    checks++; if (resp !== 4'b0001) begin errs++; $display("FAIL rr_resp0 got=%b exp=0001", resp); end
    cyc(); rsp_v = 1'b0;
  endtask

  task automatic test_stall();
    valid = 4'b0010; set_pa(1, 64'hDEAD_BEE0); ready = 1'b0;
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL stall_idle got=%b exp=0", req_valid); end
    for (int k = 0; k < 5; k++) begin
      cyc(); if (k == 1) valid = '0;
      @(negedge clock);
      checks++; if (req_valid !== 1'b1 || req_id !== 2'd1 || req_paddr !== 64'hDEAD_BEE0 || grant !== '0)
        begin errs++; $display("FAIL stall_hold[%0d] v=%b id=%0d pa=%h g=%b exp 1/1/deadbee0/0000", k, req_valid, req_id, req_paddr, grant); end
    end
    cyc(); ready = 1'b1; @(negedge clock);
    checks++; if (grant !== 4'b0010) begin errs++; $display("FAIL stall_grant got=%b exp=0010", grant); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL stall_done got=%b exp=0", req_valid); end
  endtask

  task automatic test_reissue();
    valid = 4'b1000; set_pa(3, 64'h4440);
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== 2'd3 || grant !== 4'b1000) begin errs++; $display("FAIL reiss_first v=%b id=%0d g=%b exp 1/3/1000", req_valid, req_id, grant); end
    cyc(); @(negedge clock);
    cyc(); rsp_v = 1'b1; rsp_id = 2'd3; @(negedge clock);
    checks++; if (resp !== 4'b1000 || req_valid !== 1'b0) begin errs++; $display("FAIL reiss_resp resp=%b v=%b exp 1000/0", resp, req_valid); end
    cyc(); rsp_v = 1'b0; @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL reiss_t1 got=%b exp=0", req_valid); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== 2'd3 || grant !== 4'b1000) begin errs++; $display("FAIL reiss_t2 v=%b id=%0d g=%b exp 1/3/1000", req_valid, req_id, grant); end
    cyc(); valid = '0;
  endtask

  task automatic test_async_reset();
    valid = 4'b0001; set_pa(0, 64'h7770); ready = 1'b0;
    cyc(); cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== 2'd0) begin errs++; $display("FAIL arst_pre v=%b id=%0d exp 1/0", req_valid, req_id); end
    #2 reset_n = 1'b0; valid = '0;
    #1;
    checks++; if (req_valid !== 1'b0 || req_paddr !== '0 || req_id !== '0 || grant !== '0)
      begin errs++; $display("FAIL arst_out v=%b pa=%h id=%0d g=%b exp all 0", req_valid, req_paddr, req_id, grant); end
    cyc(); cyc(); reset_n = 1'b1;
  endtask

  task automatic test_all4();
    valid = 4'b1111; ready = 1'b1;
    for (int i = 0; i < N; i++) set_pa(i, 64'hA000 + 64'(i));
    @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL all4_idle got=%b exp=0", req_valid); end
    for (int k = 0; k < N; k++) begin
      cyc(); @(negedge clock);
      checks++; if (req_valid !== 1'b1 || req_id !== IW'(k) || req_paddr !== 64'hA000 + 64'(k) || grant !== 4'(1 << k))
        begin errs++; $display("FAIL all4_issue[%0d] v=%b id=%0d pa=%h g=%b", k, req_valid, req_id, req_paddr, grant); end
    end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL all4_full got=%b exp=0", req_valid); end
    cyc(); rsp_v = 1'b1; rsp_id = 2'd2; @(negedge clock);
    checks++; if (resp !== 4'b0100) begin errs++; $display("FAIL all4_resp2 got=%b exp=0100", resp); end
    cyc(); rsp_v = 1'b0;
    cyc(); rsp_v = 1'b1; rsp_id = 2'd0; @(negedge clock);
    checks++; if (req_id !== 2'd2 || grant !== 4'b0100 || resp !== 4'b0001)
      begin errs++; $display("FAIL all4_simul id=%0d g=%b resp=%b exp 2/0100/0001", req_id, grant, resp); end
    cyc(); rsp_v = 1'b0; @(negedge clock);
    checks++; if (req_valid !== 1'b0) begin errs++; $display("FAIL all4_gap got=%b exp=0", req_valid); end
    cyc(); @(negedge clock);
    checks++; if (req_valid !== 1'b1 || req_id !== 2'd0 || grant !== 4'b0001) begin errs++; $display("FAIL all4_reiss0 v=%b id=%0d g=%b exp 1/0/0001", req_valid, req_id, grant); end
    cyc(); valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_stall();
    test_reissue();
    test_async_reset();
    test_all4();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
